// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the buffered UART transmitter:
//                transmit FSM state encoding, oversample ratio and baud
//                divider computation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit FSM states; the encoding is fixed so benches can probe it.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

    // Baud ticks per serial bit.
    localparam int c_OVERSAMPLE = 16;

    // System clocks per baud tick. Clamped to 1 so a degenerate parameter set
    // still yields a legal counter.
    function automatic int bit_ticks(input int clock_freq, input int baud);
        int ticks;
        ticks = clock_freq / (baud * c_OVERSAMPLE);
        return (ticks < 1) ? 1 : ticks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock FIFO with registered read data and registered
//                full/empty flags. Writes while full and reads while empty are
//                ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    import uart_pkg::*;

    localparam int            c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [c_AW:0]    w_count_next;
    logic [WIDTH-1:0] r_dout;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // Flags come from the pre-edge count, so a same-cycle pop never makes room.
    assign w_push = wr_en & ~r_full;
    assign w_pop  = rd_en & ~r_empty;
    assign dout   = r_dout;
    assign full   = r_full;
    assign empty  = r_empty;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage array: not reset, contents are only visible through r_dout.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, count, flags and read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered UART transmitter. Bytes are queued in a sync FIFO
//                and serialized LSB first as start/data/stop frames on tx,
//                with back-to-back frames while the FIFO has data.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] d_in,
    output logic                 full,
    output logic                 empty,
    output logic                 tx
);
    import uart_pkg::*;

    localparam int                    c_BIT_TICKS = bit_ticks(CLOCK_FREQ, BAUD);
    localparam int                    c_BAUD_W    = (c_BIT_TICKS > 1) ? $clog2(c_BIT_TICKS) : 1;
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(c_BIT_TICKS - 1);
    localparam int                    c_TICK_W    = $clog2(c_OVERSAMPLE);
    localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(c_OVERSAMPLE - 1);
    localparam int                    c_BIT_W     = $clog2(DATA_BITS + 1);
    localparam logic [c_BIT_W-1:0]    c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]    c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [c_BAUD_W-1:0]   r_baud_cnt;
    logic                  baud_tick_16x;
    logic [c_TICK_W-1:0]   tick_cnt;
    logic [c_TICK_W-1:0]   w_tick_next;
    logic [c_BIT_W-1:0]    bit_cnt;
    logic [c_BIT_W-1:0]    w_bit_next;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  r_pop_pending;
    logic                  w_pop_pending_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_bit_end;
    logic                  rd_en;
    logic                  tx_start;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic [DATA_BITS-1:0]  tx_data;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (d_in),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // The popped byte appears on fifo_dout one edge after rd_en; tx_start
    // marks that edge so the frame loads valid data.
    assign tx_start      = r_pop_pending;
    assign tx_data       = fifo_dout;
    assign tx            = r_tx;
    assign baud_tick_16x = (state != IDLE) && (r_baud_cnt == c_BAUD_LAST);
    assign w_bit_end     = baud_tick_16x && (tick_cnt == c_TICK_LAST);

    // Baud divider: parked in IDLE and cleared at frame start so every bit
    // spans exactly 16 ticks.
    always_ff @(posedge clk) begin
        if (rst || tx_start || state == IDLE || baud_tick_16x) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // FSM state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            r_pop_pending <= 1'b0;
            r_tx          <= 1'b1;
        end else begin
            state         <= state_next;
            tick_cnt      <= w_tick_next;
            bit_cnt       <= w_bit_next;
            shift_reg     <= w_shift_next;
            r_pop_pending <= w_pop_pending_next;
            r_tx          <= w_tx_next;
        end
    end

    // Next-state, FIFO pop request and next line level.
    always_comb begin
        state_next         = state;
        w_tick_next        = tick_cnt;
        w_bit_next         = bit_cnt;
        w_shift_next       = shift_reg;
        w_pop_pending_next = 1'b0;
        rd_en              = 1'b0;
        w_tx_next          = 1'b1;

        if (baud_tick_16x) begin
            w_tick_next = tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_next   = START;
                    w_shift_next = tx_data;
                    w_tick_next  = '0;
                    w_bit_next   = '0;
                end else if (!empty) begin
                    rd_en              = 1'b1;
                    w_pop_pending_next = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_next = DATA;
                    w_bit_next = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (bit_cnt == c_DATA_LAST) begin
                        state_next = STOP;
                        w_bit_next = '0;
                    end else begin
                        w_shift_next = shift_reg >> 1;
                        w_bit_next   = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (bit_cnt == c_STOP_LAST) begin
                        // Pop right away so the next frame follows with
                        // only a one-clock gap.
                        state_next = IDLE;
                        if (!empty) begin
                            rd_en              = 1'b1;
                            w_pop_pending_next = 1'b1;
                        end
                    end else begin
                        w_bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A line monitor decodes
//                frames from tx and compares them with a queue of expected
//                bytes; directed and random write bursts drive the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLOCK_FREQ  = 5_000_000;
    localparam int BAUD        = 100_000;
    localparam int DATA_BITS   = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int BIT_TICKS   = CLOCK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS    = 16 * BIT_TICKS;
    localparam int FRAME_BITS  = 1 + DATA_BITS + 1;
    localparam int FRAME_CLKS  = FRAME_BITS * BIT_CLKS;
    localparam int DRAIN_LIMIT = (FIFO_DEPTH + 3) * FRAME_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       full, empty, tx;
    logic       wr_en2 = 1'b0;
    logic [7:0] d_in2 = 8'h00;
    logic       full2, empty2, tx2;

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo #(
        .CLOCK_FREQ (CLOCK_FREQ), .BAUD (BAUD), .DATA_BITS (DATA_BITS),
        .STOP_BITS (1), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .wr_en (wr_en), .d_in (d_in),
        .full (full), .empty (empty), .tx (tx)
    );

    uart_tx_fifo #(
        .CLOCK_FREQ (CLOCK_FREQ), .BAUD (BAUD), .DATA_BITS (DATA_BITS),
        .STOP_BITS (2), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut2 (
        .clk (clk), .rst (rst), .wr_en (wr_en2), .d_in (d_in2),
        .full (full2), .empty (empty2), .tx (tx2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Line monitor: samples tx every cycle for one full frame after a falling
    // edge, checks every bit holds for exactly BIT_CLKS, and decodes the byte.
    always begin : line_monitor
        int               t0;
        bit               aborted;
        bit               shape_ok;
        logic             v;
        logic [7:0]       got;
        logic             samp [FRAME_CLKS];
        @(negedge clk);
        if (rst === 1'b0 && tx === 1'b0) begin
            t0      = cyc;
            aborted = 1'b0;
            samp[0] = tx;
            for (int j = 1; j < FRAME_CLKS; j++) begin
                @(negedge clk);
                if (rst !== 1'b0) aborted = 1'b1;
                samp[j] = tx;
            end
            if (!aborted) begin
                shape_ok = 1'b1;
                got      = 8'h00;
                for (int i = 0; i < FRAME_BITS; i++) begin
                    v = samp[i * BIT_CLKS];
                    for (int k = 1; k < BIT_CLKS; k++) begin
                        if (samp[i * BIT_CLKS + k] !== v) shape_ok = 1'b0;
                    end
                    if (i == 0 && v !== 1'b0) shape_ok = 1'b0;
                    if (i == FRAME_BITS - 1 && v !== 1'b1) shape_ok = 1'b0;
                    if (i > 0 && i <= DATA_BITS) got[i - 1] = v;
                end
                start_q.push_back(t0);
                check("frame_shape", shape_ok, 1);
                check("frame_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_byte", got, exp_q.pop_front());
            end
        end
    end

    // Consecutive-cycle write burst from an idle line. The first byte is popped
    // one edge after it lands and no further pop happens within the burst, so
    // the occupancy after write k is 1 for k<=2, else k-1, capped at the depth;
    // at most FIFO_DEPTH+1 bytes are accepted.
    task automatic burst(input int len, input int base, output int w0, output int acc);
        logic [7:0] b;
        int         occ;
        acc = 0;
        w0  = 0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            b     = (base >= 0) ? 8'(base + k - 1) : 8'($urandom);
            wr_en = 1'b1;
            d_in  = b;
            if (k <= FIFO_DEPTH + 1) begin
                exp_q.push_back(b);
                acc++;
            end
            @(posedge clk);
            #1;
            if (k == 1) w0 = cyc;
            occ = (k == 1) ? 1 : ((k - 1 > FIFO_DEPTH) ? FIFO_DEPTH : k - 1);
            check("full_after_write", full, (occ == FIFO_DEPTH));
            check("empty_after_write", empty, 0);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < DRAIN_LIMIT) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_tx", tx, 1);
        check("idle_empty", empty, 1);
        check("idle_full", full, 0);
        check("idle_state", dut.state, 2'b00);
    endtask

    task automatic check_frames(input int s0, input int w0, input int acc);
        bit gaps_ok = 1'b1;
        int d;
        check("frame_count", start_q.size() - s0, acc);
        if (start_q.size() > s0) check("first_latency", start_q[s0] - w0, 2);
        for (int i = s0; i + 1 < start_q.size(); i++) begin
            d = start_q[i + 1] - start_q[i];
            if (d < FRAME_CLKS || d > FRAME_CLKS + 2) gaps_ok = 1'b0;
        end
        check("back_to_back_gap", gaps_ok, 1);
    endtask

    task automatic wait_tx2(input logic lvl, output int t);
        int n = 0;
        @(negedge clk);
        while (tx2 !== lvl && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("tx2_level_reached", tx2, lvl);
    endtask

    initial begin
        int s0, w0, acc, n, zeros, t_f1, t_r1, t_f2;

        // Reset held for 10 clocks.
        repeat (10) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_state", dut.state, 2'b00);
        check("reset_tick_cnt", dut.tick_cnt, 0);
        check("reset_tx2", tx2, 1);
        check("reset_full2", full2, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single byte 0x41.
        s0 = start_q.size();
        burst(1, 'h41, w0, acc);
        drain();
        check_frames(s0, w0, acc);

        // Four consecutive bytes 0x41..0x44.
        s0 = start_q.size();
        burst(4, 'h41, w0, acc);
        drain();
        check_frames(s0, w0, acc);

        // 18 consecutive writes: 17 accepted, the last one dropped.
        s0 = start_q.size();
        burst(18, -1, w0, acc);
        drain();
        check_frames(s0, w0, acc);

        // Random-length random-data bursts.
        for (int r = 0; r < 3; r++) begin
            s0 = start_q.size();
            burst($urandom_range(1, FIFO_DEPTH + 3), -1, w0, acc);
            drain();
            check_frames(s0, w0, acc);
        end

        // Reset in the middle of the data bits of a frame.
        burst(3, 'h5A, w0, acc);
        n = 0;
        while (tx !== 1'b0 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("tx_fell_before_reset", tx, 0);
        repeat (4 * BIT_CLKS) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_empty", empty, 1);
        check("midreset_full", full, 0);
        check("midreset_state", dut.state, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        s0    = start_q.size();
        zeros = 0;
        repeat (2 * FRAME_CLKS) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("no_line_activity_after_reset", zeros, 0);
        check("no_frames_after_reset", start_q.size() - s0, 0);

        // Two stop bits: two 0x00 bytes so the high run is the stop level alone.
        @(negedge clk);
        wr_en2 = 1'b1;
        d_in2  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        wr_en2 = 1'b0;
        wait_tx2(1'b0, t_f1);
        wait_tx2(1'b1, t_r1);
        wait_tx2(1'b0, t_f2);
        check("stop2_low_run", t_r1 - t_f1, 9 * BIT_CLKS);
        check("stop2_high_run_ok",
              (t_f2 - t_r1 >= 2 * BIT_CLKS) && (t_f2 - t_r1 <= 2 * BIT_CLKS + 2), 1);
        check("stop2_frame_period_ok",
              (t_f2 - t_f1 >= 11 * BIT_CLKS) && (t_f2 - t_f1 <= 11 * BIT_CLKS + 2), 1);
        check("stop2_empty_after_pops", empty2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
